// File: rtl/integer_result_buffer_if.sv
// Bus between the ALU/commit stages and integer_result_buffer.
// The master drives ALU results and the consumer acknowledge; the slave returns the head entry and stall.
interface integer_result_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic [XLEN-1:0] result_i;
    logic [4:0]      reg_dest_i;
    logic            is_branch_i;
    logic            branch_taken_i;
    logic            data_valid_i;
    logic            read_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      reg_dest_o;
    logic            is_branch_o;
    logic            branch_taken_o;
    logic            data_valid_o;
    logic            stall_o;

    modport master (
        output flush_i, result_i, reg_dest_i, is_branch_i, branch_taken_i, data_valid_i, read_i,
        input  result_o, reg_dest_o, is_branch_o, branch_taken_o, data_valid_o, stall_o
    );

    modport slave (
        input  flush_i, result_i, reg_dest_i, is_branch_i, branch_taken_i, data_valid_i, read_i,
        output result_o, reg_dest_o, is_branch_o, branch_taken_o, data_valid_o, stall_o
    );
endinterface

// File: rtl/integer_result_buffer.sv
// Circular FIFO holding ALU results until writeback acknowledges them.
// Optional same-cycle bypass of an empty buffer is enabled with `define INT_RESULT_BYPASS_EN.
module integer_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input logic                   clk_i,
    input logic                   rst_i,
    integer_result_buffer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DEST_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [DEST_W-1:0] reg_dest;
        logic              is_branch;
        logic              branch_taken;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    entry_t            in_entry;
    entry_t            head;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign in_entry = '{result:       bus.result_i,
                        reg_dest:     bus.reg_dest_i,
                        is_branch:    bus.is_branch_i,
                        branch_taken: bus.branch_taken_i};

    // A pop only ever takes a stored entry; a bypassed result never touches the pointers.
    assign pop = bus.read_i && !empty;

`ifdef INT_RESULT_BYPASS_EN
    logic bypass_consume;
    assign bypass_consume = empty && bus.data_valid_i && bus.read_i;
    assign push = bus.data_valid_i && (!full || pop) && !bypass_consume;
`else
    assign push = bus.data_valid_i && (!full || pop);
`endif

    // Pointer and occupancy tracking; flush outranks push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Entry storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push && !bus.flush_i) mem[wr_ptr] <= in_entry;
    end

    always_comb begin
        bus.result_o       = '0;
        bus.reg_dest_o     = '0;
        bus.is_branch_o    = 1'b0;
        bus.branch_taken_o = 1'b0;
        bus.data_valid_o   = 1'b0;
        if (!empty) begin
            bus.result_o       = head.result;
            bus.reg_dest_o     = head.reg_dest;
            bus.is_branch_o    = head.is_branch;
            bus.branch_taken_o = head.branch_taken;
            bus.data_valid_o   = 1'b1;
        end
`ifdef INT_RESULT_BYPASS_EN
        else if (bus.data_valid_i) begin
            bus.result_o       = in_entry.result;
            bus.reg_dest_o     = in_entry.reg_dest;
            bus.is_branch_o    = in_entry.is_branch;
            bus.branch_taken_o = in_entry.branch_taken;
            bus.data_valid_o   = 1'b1;
        end
`endif
    end

    assign bus.stall_o = full;
endmodule

// File: tb/tb_integer_result_buffer.sv
// Self-checking bench for integer_result_buffer: directed scenarios plus random traffic
// compared against a queue-based model of the result FIFO.
module tb_integer_result_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      dst;
        logic            br;
        logic            tk;
    } ent_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];

    integer_result_buffer_if #(.XLEN(XLEN)) bus ();

    integer_result_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush_i        = 1'b0;
        bus.result_i       = '0;
        bus.reg_dest_i     = '0;
        bus.is_branch_i    = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.data_valid_i   = 1'b0;
        bus.read_i         = 1'b0;
    endtask

    // Expected outputs: head of the model queue, or (bypass build) the live input when empty.
    task automatic check_outputs(input string tag);
        ent_t e;
        logic v;
        e = '0;
        v = 1'b0;
        if (q.size() != 0) begin
            e = q[0];
            v = 1'b1;
        end
`ifdef INT_RESULT_BYPASS_EN
        else if (bus.data_valid_i) begin
            e = '{bus.result_i, bus.reg_dest_i, bus.is_branch_i, bus.branch_taken_i};
            v = 1'b1;
        end
`endif
        chk({tag, ".result"},    64'(bus.result_o),       64'(e.result));
        chk({tag, ".reg_dest"},  64'(bus.reg_dest_o),     64'(e.dst));
        chk({tag, ".is_branch"}, 64'(bus.is_branch_o),    64'(e.br));
        chk({tag, ".taken"},     64'(bus.branch_taken_o), 64'(e.tk));
        chk({tag, ".valid"},     64'(bus.data_valid_o),   64'(v));
        chk({tag, ".stall"},     64'(bus.stall_o),        64'(q.size() == DEPTH));
    endtask

    // One clock: drive inputs, check pre-edge outputs, clock, update model, return inputs to idle.
    task automatic cycle(input string tag, input logic fl, input logic dv, input logic rd,
                         input logic [XLEN-1:0] res, input logic [4:0] dst,
                         input logic br, input logic tk);
        logic was_empty;
        logic popped;
        logic consumed;
        bus.flush_i        = fl;
        bus.data_valid_i   = dv;
        bus.read_i         = rd;
        bus.result_i       = res;
        bus.reg_dest_i     = dst;
        bus.is_branch_i    = br;
        bus.branch_taken_i = tk;
        #1;
        check_outputs(tag);
        @(posedge clk_i);
        was_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
        end else begin
            popped   = rd && !was_empty;
            consumed = 1'b0;
`ifdef INT_RESULT_BYPASS_EN
            consumed = was_empty && dv && rd;
`endif
            if (popped) void'(q.pop_front());
            if (dv && !consumed && (q.size() < DEPTH))
                q.push_back('{res, dst, br, tk});
        end
        #1;
        idle();
    endtask

    initial begin
        idle();

        // Power-on reset
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("por");
        rst_i = 1'b0;
        #2;
        check_outputs("por_release");

        // Single push, hold, then pop
        cycle("single_push", 0, 1, 0, 32'h0000_0010, 5'd5, 0, 0);
        chk("single_result", 64'(bus.result_o), 64'h10);
        chk("single_dest",   64'(bus.reg_dest_o), 64'd5);
        chk("single_valid",  64'(bus.data_valid_o), 64'd1);
        for (int i = 0; i < 3; i++) cycle("single_hold", 0, 0, 0, 32'h0, 5'd0, 0, 0);
        chk("single_hold_result", 64'(bus.result_o), 64'h10);
        cycle("single_pop", 0, 0, 1, 32'h0, 5'd0, 0, 0);
        chk("single_empty_valid", 64'(bus.data_valid_o), 64'd0);

        // Fill, simultaneous pop+push while full, drain with wrapped write pointer
        for (int i = 1; i <= 4; i++) cycle("fill", 0, 1, 0, XLEN'(i), 5'(i), 0, 0);
        chk("fill_stall", 64'(bus.stall_o), 64'd1);
        cycle("full_pop_push", 0, 1, 1, 32'h5, 5'd5, 0, 0);
        chk("full_pop_push_stall", 64'(bus.stall_o), 64'd1);
        cycle("full_overflow", 0, 1, 0, 32'h99, 5'd9, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            chk("drain_order", 64'(bus.result_o), 64'(k));
            cycle("drain", 0, 0, 1, 32'h0, 5'd0, 0, 0);
            if (k == 2) chk("drain_stall_fall", 64'(bus.stall_o), 64'd0);
        end
        chk("drain_done", 64'(bus.data_valid_o), 64'd0);

        // Branch fields
        cycle("branch_push", 0, 1, 0, 32'h8000_0004, 5'd3, 1, 1);
        chk("branch_is", 64'(bus.is_branch_o), 64'd1);
        chk("branch_taken", 64'(bus.branch_taken_o), 64'd1);
        chk("branch_result", 64'(bus.result_o), 64'h8000_0004);
        cycle("branch_pop", 0, 0, 1, 32'h0, 5'd0, 0, 0);

        // Flush outranks a concurrent push and pop
        cycle("flush_fill", 0, 1, 0, 32'hA, 5'd1, 0, 0);
        cycle("flush_fill", 0, 1, 0, 32'hB, 5'd2, 0, 0);
        cycle("flush", 1, 1, 1, 32'hC, 5'd3, 0, 0);
        chk("flush_valid", 64'(bus.data_valid_o), 64'd0);
        chk("flush_stall", 64'(bus.stall_o), 64'd0);
        cycle("after_flush", 0, 0, 0, 32'h0, 5'd0, 0, 0);

        // Empty buffer with a read-acknowledged result
        bus.data_valid_i = 1'b1;
        bus.read_i       = 1'b1;
        bus.result_i     = 32'hDEAD_BEEF;
        #1;
`ifdef INT_RESULT_BYPASS_EN
        chk("bypass_same_valid",  64'(bus.data_valid_o), 64'd1);
        chk("bypass_same_result", 64'(bus.result_o), 64'hDEAD_BEEF);
`else
        chk("nobypass_same_valid", 64'(bus.data_valid_o), 64'd0);
`endif
        cycle("bypass", 0, 1, 1, 32'hDEAD_BEEF, 5'd7, 0, 0);
`ifdef INT_RESULT_BYPASS_EN
        chk("bypass_next_valid", 64'(bus.data_valid_o), 64'd0);
`else
        chk("nobypass_next_valid",  64'(bus.data_valid_o), 64'd1);
        chk("nobypass_next_result", 64'(bus.result_o), 64'hDEAD_BEEF);
        cycle("nobypass_pop", 0, 0, 1, 32'h0, 5'd0, 0, 0);
`endif

        // Random traffic, including occasional flushes and pushes into a full buffer
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  logic'($urandom_range(0, 31) == 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 2) != 0),
                  XLEN'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset with three entries held
        cycle("pre_rst_flush", 1, 0, 0, 32'h0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("pre_rst", 0, 1, 0, XLEN'(32'h100 + i), 5'(i), 1, 0);
        chk("pre_rst_valid", 64'(bus.data_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        q.delete();
        #1;
        check_outputs("async_rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check_outputs("rst_release");
        cycle("post_rst", 0, 0, 1, 32'h0, 5'd0, 0, 0);
        chk("post_rst_valid", 64'(bus.data_valid_o), 64'd0);
        chk("post_rst_stall", 64'(bus.stall_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
